reorder_buffer: RTL
===================

Name: reorder_buffer

Overview:
- Circular in-order retirement queue of the RV32IM out-of-order core. Sits directly upstream of the commit controller.
- Dispatch allocates an entry per instruction and receives its tag. Functional-unit writeback marks the entry done.
- Exposes head status to the commit controller as commit_ready and cir_q_empty. On the controller's registered commit pulse, pops the head and drives the architectural regfile write.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- TAG_W, 3, tag width; equals $clog2(DEPTH).
- XLEN, 32, result data width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  discard all entries (mispredict/exception).
- alloc_valid  in  1  dispatch requests one entry.
- alloc_rd  in  5  destination register of the allocating instruction.
- alloc_ready  out  1  entry available (count < DEPTH).
- alloc_tag  out  TAG_W  tag assigned on accepted alloc; equals tail pointer.
- wb_valid  in  1  functional-unit result valid.
- wb_tag  in  TAG_W  entry being written back.
- wb_data  in  XLEN  result value.
- commit  in  1  pop request from commit controller; registered on its side.
- commit_ready  out  1  head (as defined below) is done.
- cir_q_empty  out  1  no committable entry (as defined below).
- commit_we  out  1  regfile write enable for the popped entry.
- commit_rd  out  5  destination register of the popped entry.
- commit_data  out  XLEN  result of the popped entry.
- count  out  TAG_W+1  occupied entries.

Behaviour:
- Storage: per entry valid, done, rd[4:0], data[XLEN-1:0]. Pointers head and tail are TAG_W bits and wrap modulo DEPTH. count is tracked explicitly.
- Reset (rst=1): head=tail=0, count=0, all valid/done=0.
  - Outputs: alloc_ready=1, alloc_tag=0, commit_ready=0, cir_q_empty=1, commit_we=0.
- Flush: identical to reset, one cycle.
  - Flush has priority over alloc, wb and commit in the same cycle; commit_we=0 that cycle.
- Alloc accepted when alloc_valid && alloc_ready.
  - Entry[tail] gets valid=1, done=0, rd=alloc_rd; tail++.
  - alloc_ready uses the current count only; a same-cycle pop does not free a slot.
- Writeback: if wb_valid and entry[wb_tag].valid, set done=1 and data=wb_data (takes effect next cycle).
  - wb to an invalid entry is ignored.
  - wb and alloc to the same index in one cycle: alloc wins (done=0).
- Pop occurs when commit && count!=0 && entry[head].done && !flush.
  - Clear entry[head].valid and entry[head].done; head++.
  - commit_we=1 combinationally that cycle; commit_rd and commit_data come from entry[head].
  - commit_we=0 if rd==0 (x0 never written).
  - commit asserted with no valid done head: ignored, no state change, commit_we=0.
- Lookahead, required because the commit controller registers commit one cycle after sampling:
  - If commit=0: commit_ready = entry[head].done && count!=0; cir_q_empty = (count==0).
  - If commit=1: commit_ready = (count>=2) && entry[head+1].done; cir_q_empty = (count<=1).
  - This guarantees back-to-back pops only when the next head is already done.
- Simultaneous alloc + pop: count unchanged, both pointers advance.
- Pointer wrap: tail and head wrap DEPTH-1 -> 0 with no bubble.
- Combinational outputs: alloc_ready, alloc_tag, commit_ready, cir_q_empty, commit_* and count depend only on registered state plus commit/flush. No input-to-output path from alloc or wb.

Test Plan:
- Reset then idle -> alloc_ready=1, cir_q_empty=1, commit_ready=0, count=0, commit_we=0.
- Allocate rd=5, wb tag0 data=0xDEADBEEF, drive commit next cycle -> commit_ready=1 one cycle after wb; pop cycle shows commit_we=1, rd=5, data=0xDEADBEEF; count returns to 0.
- Allocate 8 entries -> alloc_ready=0 with count=8; a 9th alloc is ignored. Write back out of order (tags 3,1,0,2...) -> retirement order is strictly tags 0..7. Continuous commit retires one per cycle once all are done; wrap continues with next alloc tag=0.
- Entries 0 and 1 allocated, only tag0 done, commit held high -> tag0 pops; while commit=1, commit_ready=0 and cir_q_empty=0; no pop of tag1 until its wb arrives.
- Allocate rd=0 then commit -> pop occurs, head advances, commit_we=0.
- Flush with 5 entries in flight plus same-cycle commit and wb -> no commit_we; next cycle count=0, alloc_tag=0, cir_q_empty=1.

Source files
------------

// File: rtl/reorder_buffer_if.sv
// Dispatch, writeback and commit signals of the reorder buffer.
// The slave modport is the buffer itself; the master modport is the surrounding core (or a bench).
interface reorder_buffer_if #(
  parameter int DEPTH = 8,
  parameter int TAG_W = $clog2(DEPTH),
  parameter int XLEN  = 32
);
  logic             flush;
  logic             alloc_valid;
  logic [4:0]       alloc_rd;
  logic             alloc_ready;
  logic [TAG_W-1:0] alloc_tag;
  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;
  logic [XLEN-1:0]  wb_data;
  logic             commit;
  logic             commit_ready;
  logic             cir_q_empty;
  logic             commit_we;
  logic [4:0]       commit_rd;
  logic [XLEN-1:0]  commit_data;
  logic [TAG_W:0]   count;

  modport slave (
    input  flush, alloc_valid, alloc_rd, wb_valid, wb_tag, wb_data, commit,
    output alloc_ready, alloc_tag, commit_ready, cir_q_empty,
           commit_we, commit_rd, commit_data, count
  );

  modport master (
    output flush, alloc_valid, alloc_rd, wb_valid, wb_tag, wb_data, commit,
    input  alloc_ready, alloc_tag, commit_ready, cir_q_empty,
           commit_we, commit_rd, commit_data, count
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order retirement queue: allocate at tail, mark done on writeback, pop done head on commit.
// Head status is presented with one-entry lookahead because the commit controller registers its pop.
module reorder_buffer #(
  parameter int DEPTH = 8,
  parameter int TAG_W = $clog2(DEPTH),
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  reorder_buffer_if.slave rob
);

  localparam logic [TAG_W:0] FULL = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0] TWO  = (TAG_W+1)'(2);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] done_q,  done_d;
  logic [4:0]       rd_q   [DEPTH];
  logic [4:0]       rd_d   [DEPTH];
  logic [XLEN-1:0]  data_q [DEPTH];
  logic [XLEN-1:0]  data_d [DEPTH];
  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;

  logic             alloc_ok;
  logic             pop;
  logic [TAG_W-1:0] head_nxt;

  assign head_nxt = head_q + 1'b1;
  // Capacity is judged on the current count only; a same-cycle pop never frees a slot.
  assign alloc_ok = rob.alloc_valid && (count_q != FULL) && !rob.flush;
  assign pop      = rob.commit && (count_q != '0) && done_q[head_q] && !rob.flush;

  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    rd_d    = rd_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rob.flush) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (rob.wb_valid && valid_q[rob.wb_tag]) begin
        done_d[rob.wb_tag] = 1'b1;
        data_d[rob.wb_tag] = rob.wb_data;
      end
      // Applied after writeback so an alloc to the same slot leaves it not-done.
      if (alloc_ok) begin
        valid_d[tail_q] = 1'b1;
        done_d[tail_q]  = 1'b0;
        rd_d[tail_q]    = rob.alloc_rd;
        tail_d          = tail_q + 1'b1;
      end
      if (pop) begin
        valid_d[head_q] = 1'b0;
        done_d[head_q]  = 1'b0;
        head_d          = head_nxt;
      end
      case ({alloc_ok, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    rob.alloc_ready = (count_q != FULL);
    rob.alloc_tag   = tail_q;
    rob.count       = count_q;
    rob.commit_we   = pop && (rd_q[head_q] != 5'd0);
    rob.commit_rd   = rd_q[head_q];
    rob.commit_data = data_q[head_q];
    if (rob.commit) begin
      rob.commit_ready = (count_q >= TWO) && done_q[head_nxt];
      rob.cir_q_empty  = (count_q < TWO);
    end else begin
      rob.commit_ready = (count_q != '0) && done_q[head_q];
      rob.cir_q_empty  = (count_q == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    rd_q   <= rd_d;
    data_q <= data_d;
  end

endmodule
